// File: rtl/rf_writeback_pkg.sv
// Shared core constants and types for the register-file writeback block.
package rf_writeback_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 32;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_MDU  = 2'd2
  } wb_src_e;

endpackage

// File: rtl/rf_writeback_fifo.sv
// Small power-of-two FIFO holding pending mul/div results ahead of the write port.
module wb_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  // A full queue may still take a push when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/rf_writeback.sv
// Register-file writeback arbiter: merges ALU and queued mul/div results onto
// one write port and tracks pending long-latency destinations for hazard stalls.
module rf_writeback
  import rf_writeback_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int MQ_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 iss_valid,
  input  logic                 iss_long,
  input  logic [REG_IDX_W-1:0] iss_rd,
  input  logic [REG_IDX_W-1:0] iss_rs1,
  input  logic [REG_IDX_W-1:0] iss_rs2,
  output logic                 iss_stall,
  input  logic                 alu_valid,
  input  logic [REG_IDX_W-1:0] alu_rd,
  input  logic [XLEN-1:0]      alu_wdata,
  output logic                 alu_stall,
  input  logic                 mdu_valid,
  input  logic [REG_IDX_W-1:0] mdu_rd,
  input  logic [XLEN-1:0]      mdu_wdata,
  output logic                 mdu_ready,
  output logic [REG_IDX_W-1:0] rd,
  output logic                 rd_we,
  output logic [XLEN-1:0]      rd_wdata,
  output logic [NUM_REGS-1:0]  busy
);

  localparam int EW = REG_IDX_W + XLEN;

  logic [EW-1:0]        q_rdata;
  logic                 q_full, q_empty, q_push, q_pop;
  logic [REG_IDX_W-1:0] head_rd;
  logic [XLEN-1:0]      head_data;
  wb_src_e              src;

  logic [REG_IDX_W-1:0] rd_q, rd_d;
  logic                 we_q, we_d;
  logic [XLEN-1:0]      wdata_q, wdata_d;
  logic [NUM_REGS-1:0]  busy_q, busy_d;

  wb_fifo #(
    .W     (EW),
    .DEPTH (MQ_DEPTH)
  ) u_mq (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (q_push),
    .wdata ({mdu_rd, mdu_wdata}),
    .pop   (q_pop),
    .rdata (q_rdata),
    .full  (q_full),
    .empty (q_empty)
  );

  assign head_rd   = q_rdata[EW-1 -: REG_IDX_W];
  assign head_data = q_rdata[XLEN-1:0];

  assign mdu_ready = !q_full;
  assign q_push    = mdu_valid && mdu_ready;
  assign q_pop     = (src == SRC_MDU);
  assign alu_stall = alu_valid && (src == SRC_MDU);
  // Stall is computed from pre-edge busy, so a same-cycle clear still stalls.
  assign iss_stall = iss_valid &&
                     (busy_q[iss_rs1] || busy_q[iss_rs2] || busy_q[iss_rd]);

  always_comb begin
    src = SRC_NONE;
    if (q_full)         src = SRC_MDU;
    else if (alu_valid) src = SRC_ALU;
    else if (!q_empty)  src = SRC_MDU;
  end

  always_comb begin
    rd_d    = rd_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    busy_d  = busy_q;
    unique case (src)
      SRC_ALU: begin
        if (alu_rd != '0) begin
          rd_d    = alu_rd;
          wdata_d = alu_wdata;
          we_d    = 1'b1;
        end
      end
      SRC_MDU: begin
        if (head_rd != '0) begin
          rd_d    = head_rd;
          wdata_d = head_data;
          we_d    = 1'b1;
        end
        busy_d[head_rd] = 1'b0;
      end
      default: ;
    endcase
    if (iss_valid && iss_long && !iss_stall && (iss_rd != '0))
      busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      busy_q  <= '0;
    end else begin
      rd_q    <= rd_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end

  assign rd       = rd_q;
  assign rd_we    = we_q;
  assign rd_wdata = wdata_q;
  assign busy     = busy_q;

endmodule
